booth_seq_ctrl: RTL and testbench

Sequential radix-4 Booth multiplier controller that drives one external `decoder_8`-style partial-product decoder. It computes a signed 32x32 -> 64 product over 16 iterations. Each cycle it presents one Booth digit to the decoder and accumulates the returned partial product, shifted by the digit weight. It sits between the operand-issue logic and the product consumer, and exchanges a start/busy/done handshake with the issuer.

---
 rtl/booth_seq_ctrl_if.sv | 14 +
 rtl/booth_seq_ctrl.sv | 58 +++++
 tb/tb_booth_seq_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_if.sv
// booth_seq_ctrl_if: issuer/consumer handshake plus decoder link for the Booth controller
interface booth_seq_ctrl_if #(parameter int N = 64);
  logic          start;
  logic [31:0]   a;
  logic [31:0]   b;
  logic          busy;
  logic          done;
  logic [N-1:0]  p;
  logic [2:0]    dec_cntrl;
  logic [31:0]   dec_a;
  logic [N-1:0]  dec_y;
  modport master (output start, a, b, dec_y, input busy, done, p, dec_cntrl, dec_a);
  modport slave  (input start, a, b, dec_y, output busy, done, p, dec_cntrl, dec_a);
endinterface

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequential radix-4 Booth multiplier controller, signed 32x32 over 16 digits
module booth_seq_ctrl #(
  parameter int N = 64
) (
  input logic           clk,
  input logic           rst_n,
  booth_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state_q;
  logic [N-1:0]  acc_q, p_q, acc_d;
  logic [32:0]   m_q;
  logic [3:0]    k_q;
  logic [31:0]   a_q;
  logic          busy_q, done_q, accept;
  assign accept        = bus.start && state_q != RUN;
  assign acc_d         = acc_q + (bus.dec_y << {k_q, 1'b0});
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.p         = p_q;
  assign bus.dec_a     = a_q;
  assign bus.dec_cntrl = state_q == RUN ? m_q[2:0] : 3'b000;
  // FSM: accept operands, walk 16 Booth digits accumulating weighted partial products, publish p
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        a_q     <= bus.a;
        m_q     <= {bus.b, 1'b0};
        acc_q   <= '0;
        k_q     <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_d;
        m_q   <= {{2{m_q[32]}}, m_q[32:2]};
        k_q   <= k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          p_q     <= acc_d;
        end
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed and random checks of the Booth controller against a decoder model
module tb_booth_seq_ctrl;
  localparam int N = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  booth_seq_ctrl_if #(.N(N)) bus();
  booth_seq_ctrl #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0]  a2;
  logic [N-1:0] sa, s2;
  logic [2:0]   c;
  assign c  = bus.dec_cntrl;
  assign a2 = bus.dec_a << 1;
  assign sa = {{32{bus.dec_a[31]}}, bus.dec_a};
  assign s2 = {{32{a2[31]}}, a2};
  assign bus.dec_y = (c == 3'd1 || c == 3'd2) ? sa :
                     c == 3'd3 ? s2 :
                     c == 3'd4 ? -s2 :
                     (c == 3'd5 || c == 3'd6) ? -sa : '0;
  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic mul(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic [N-1:0] e, input bit noise);
    int n, nb;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    nb = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nb++;
      if (noise) begin
        bus.start = (n >= 2 && n <= 9);
        bus.a = ~x;
        bus.b = y ^ 32'h5a5a_5a5a;
      end
      step();
      n++;
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, n, 16);
    chk({tag, "_busy"}, nb, 16);
    chk({tag, "_p"}, bus.p, e);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("idle_cntrl", bus.busy ? 3'b000 : bus.dec_cntrl, 0);
      chk("busy_done", bus.busy & bus.done, 0);
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, nd;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("rst_p", bus.p, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cntrl", bus.dec_cntrl, 0);
    chk("rst_deca", bus.dec_a, 0);
    step();
    rst_n = 1'b1;
    step();
    mul("m3x5", 32'd3, 32'd5, 64'd15, 1'b0);
    repeat (10) step();
    chk("hold_p", bus.p, 64'd15);
    chk("hold_done", bus.done, 0);
    mul("neg", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    step();
    mul("zero", 32'd0, 32'h7FFF_FFFF, 64'd0, 1'b0);
    step();
    mul("bmin", 32'd1, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    step();
    mul("amin", 32'hC000_0000, 32'h8000_0000, 64'h2000_0000_0000_0000, 1'b0);
    step();
    mul("ign", 32'd12, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFDC, 1'b1);
    step();
    bus.a = 32'd100;
    bus.b = 32'hFFFF_FFF7;
    bus.start = 1'b1;
    step();
    n = 0;
    while (!bus.done && n < 40) begin step(); n++; end
    chk("b2b_first_lat", n, 16);
    chk("b2b_first_p", bus.p, 64'hFFFF_FFFF_FFFF_FC7C);
    for (int r = 0; r < 2; r++) begin
      step();
      n = 1;
      while (!bus.done && n < 40) begin step(); n++; end
      chk("b2b_gap", n, 17);
      chk("b2b_p", bus.p, 64'hFFFF_FFFF_FFFF_FC7C);
    end
    bus.start = 1'b0;
    step();
    step();
    bus.a = 32'd5;
    bus.b = 32'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_p", bus.p, 0);
    chk("abort_cntrl", bus.dec_cntrl, 0);
    step();
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) nd++;
      step();
    end
    chk("abort_nodone", nd, 0);
    chk("abort_p_after", bus.p, 0);
    mul("post_rst", 32'd5, 32'd5, 64'd25, 1'b0);
    step();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r, x, y;
      logic signed [63:0] sx, sy;
      r = $urandom;
      x = {r[30], r[30:0]};
      y = $urandom;
      sx = $signed(x);
      sy = $signed(y);
      mul("rnd", x, y, sx * sy, 1'b0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
